// File: rtl/nanotrade_pkg.sv
// Shared market event definitions used by the arbiter and the feature extractor.
// Also holds the round-robin pick helper used by the arbiter.
package nanotrade_pkg;

  typedef enum logic [1:0] {
    EVT_PRICE  = 2'd0,
    EVT_VOLUME = 2'd1,
    EVT_BUY    = 2'd2,
    EVT_SELL   = 2'd3
  } evt_type_e;

  localparam int N_CH   = 4;
  localparam int DATA_W = 12;

  // Returns {found, index}; the lowest offset from ptr among set req bits wins.
  function automatic logic [2:0] rr_pick(input logic [3:0] req, input logic [1:0] ptr);
    logic [2:0] pick;
    logic [1:0] idx;
    pick = 3'b000;
    for (int i = 3; i >= 0; i--) begin
      idx = ptr + 2'(i);
      if (req[idx]) begin
        pick = {1'b1, idx};
      end else begin
        pick = pick;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/evt_fifo.sv
// Single-clock event FIFO with registered occupancy count.
// Pushes into a full FIFO and pops from an empty one are ignored.
module evt_fifo #(
  parameter int AW = 2,
  parameter int DW = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty
);

  localparam int         DEPTH    = 1 << AW;
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [DW-1:0] mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   count_r;
  logic          full_s;
  logic          empty_s;
  logic          push_s;
  logic          pop_s;

  assign full_s  = (count_r == FULL_CNT);
  assign empty_s = (count_r == '0);
  assign push_s  = push & ~full_s;
  assign pop_s   = pop & ~empty_s;

  assign rdata = mem_r[rd_ptr_r];
  assign count = count_r;
  assign full  = full_s;
  assign empty = empty_s;

  // Storage array write; contents are don't-care while empty, so no reset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= wdata;
    end
  end

  // Pointer and occupancy update; a simultaneous push and pop keeps the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + (AW+1)'(1);
        2'b01:   count_r <= count_r - (AW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/market_event_arbiter.sv
// Buffers four market event channels and forwards one event per cycle,
// round-robin, onto the price/volume buses of the feature extractor.
module market_event_arbiter
  import nanotrade_pkg::*;
#(
  parameter int          FIFO_AW   = 2,
  parameter logic [11:0] RST_LEVEL = 12'd100
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [3:0]               src_valid,
  input  logic [47:0]              src_data,
  output logic [3:0]               src_ready,
  output logic [1:0]               out_type,
  output logic [11:0]              out_price,
  output logic [11:0]              out_volume,
  output logic                     out_valid,
  output logic [4*(FIFO_AW+1)-1:0] fifo_level,
  output logic [15:0]              event_count
);

  localparam int LW = FIFO_AW + 1;

  logic [3:0]  full_s;
  logic [3:0]  empty_s;
  logic [3:0]  ready_s;
  logic [3:0]  pop_s;
  logic [11:0] head_s [N_CH];

  logic [1:0]  rr_ptr_r;
  logic [2:0]  pick_s;
  logic        grant_s;
  logic [1:0]  gidx_s;
  logic [11:0] gdata_s;

  logic        out_valid_r, out_valid_nxt_s;
  logic [1:0]  out_type_r, out_type_nxt_s;
  logic [11:0] out_price_r, out_price_nxt_s;
  logic [11:0] out_volume_r, out_volume_nxt_s;
  logic [11:0] last_price_r, last_price_nxt_s;
  logic [15:0] event_cnt_r, event_cnt_nxt_s;
  logic [1:0]  rr_ptr_nxt_s;

  // Ready depends only on registered FIFO state (and reset), never on src_valid.
  assign ready_s   = ~full_s & {4{~rst}};
  assign src_ready = ready_s;

  for (genvar c = 0; c < N_CH; c++) begin : g_fifo
    evt_fifo #(
      .AW (FIFO_AW),
      .DW (DATA_W)
    ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (src_valid[c] & ready_s[c]),
      .pop   (pop_s[c]),
      .wdata (src_data[12*c +: 12]),
      .rdata (head_s[c]),
      .count (fifo_level[LW*c +: LW]),
      .full  (full_s[c]),
      .empty (empty_s[c])
    );
  end

  assign pick_s  = rr_pick(~empty_s, rr_ptr_r);
  assign grant_s = pick_s[2];
  assign gidx_s  = pick_s[1:0];
  assign gdata_s = head_s[gidx_s];
  assign pop_s   = grant_s ? (4'b0001 << gidx_s) : 4'b0000;

  // Next-state for the output bus, replay register, pointer and counter.
  always_comb begin
    out_valid_nxt_s  = 1'b0;
    out_type_nxt_s   = 2'd0;
    out_price_nxt_s  = last_price_r;
    out_volume_nxt_s = out_volume_r;
    last_price_nxt_s = last_price_r;
    rr_ptr_nxt_s     = rr_ptr_r;
    event_cnt_nxt_s  = event_cnt_r;
    if (grant_s) begin
      out_valid_nxt_s = 1'b1;
      out_type_nxt_s  = gidx_s;
      rr_ptr_nxt_s    = gidx_s + 2'd1;
      if (event_cnt_r != 16'hFFFF) begin
        event_cnt_nxt_s = event_cnt_r + 16'd1;
      end else begin
        event_cnt_nxt_s = event_cnt_r;
      end
      // Buy/sell drive the price bus but never touch the idle replay value.
      case (evt_type_e'(gidx_s))
        EVT_PRICE: begin
          out_price_nxt_s  = gdata_s;
          last_price_nxt_s = gdata_s;
        end
        EVT_VOLUME: begin
          out_price_nxt_s  = out_price_r;
          out_volume_nxt_s = gdata_s;
        end
        EVT_BUY:  out_price_nxt_s = gdata_s;
        EVT_SELL: out_price_nxt_s = gdata_s;
        default:  out_price_nxt_s = last_price_r;
      endcase
    end else begin
      out_valid_nxt_s = 1'b0;
    end
  end

  // Output, arbitration and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_r  <= 1'b0;
      out_type_r   <= 2'd0;
      out_price_r  <= RST_LEVEL;
      out_volume_r <= RST_LEVEL;
      last_price_r <= RST_LEVEL;
      rr_ptr_r     <= 2'd0;
      event_cnt_r  <= 16'd0;
    end else begin
      out_valid_r  <= out_valid_nxt_s;
      out_type_r   <= out_type_nxt_s;
      out_price_r  <= out_price_nxt_s;
      out_volume_r <= out_volume_nxt_s;
      last_price_r <= last_price_nxt_s;
      rr_ptr_r     <= rr_ptr_nxt_s;
      event_cnt_r  <= event_cnt_nxt_s;
    end
  end

  assign out_valid   = out_valid_r;
  assign out_type    = out_type_r;
  assign out_price   = out_price_r;
  assign out_volume  = out_volume_r;
  assign event_count = event_cnt_r;

endmodule

// File: tb/tb_market_event_arbiter.sv
// Directed bench for market_event_arbiter with hand-computed expectations.
module tb_market_event_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  src_valid;
  logic [47:0] src_data;
  logic [3:0]  src_ready;
  logic [1:0]  out_type;
  logic [11:0] out_price;
  logic [11:0] out_volume;
  logic        out_valid;
  logic [11:0] fifo_level;
  logic [15:0] event_count;

  int checks   = 0;
  int failures = 0;

  market_event_arbiter #(
    .FIFO_AW   (2),
    .RST_LEVEL (12'd100)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .src_valid   (src_valid),
    .src_data    (src_data),
    .src_ready   (src_ready),
    .out_type    (out_type),
    .out_price   (out_price),
    .out_volume  (out_volume),
    .out_valid   (out_valid),
    .fifo_level  (fifo_level),
    .event_count (event_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2:0] lvl(input int c);
    return fifo_level[3*c +: 3];
  endfunction

  task automatic reset_dut();
    src_valid = 4'b0000;
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  logic [11:0] exp_price [4];
  logic [11:0] exp_vol   [4];

  initial begin
    rst       = 1'b1;
    src_valid = 4'b0000;
    src_data  = 48'h0;
    step();
    step();
    chk("rst_ready", src_ready, 4'h0);
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_price", out_price, 12'd100);
    chk("rst_volume", out_volume, 12'd100);
    chk("rst_count", event_count, 16'd0);
    chk("rst_level", fifo_level, 12'h000);
    rst = 1'b0;
    #1;
    chk("ready_after_rst", src_ready, 4'hF);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("replay_valid", out_valid, 1'b0);
      chk("replay_type", out_type, 2'd0);
      chk("replay_price", out_price, 12'd100);
      chk("replay_volume", out_volume, 12'd100);
    end

    // single price event
    src_valid = 4'b0001;
    src_data[11:0] = 12'h2A0;
    step();
    src_valid = 4'b0000;
    chk("px_latency_valid", out_valid, 1'b0);
    chk("px_level", lvl(0), 3'd1);
    step();
    chk("px_valid", out_valid, 1'b1);
    chk("px_type", out_type, 2'd0);
    chk("px_price", out_price, 12'h2A0);
    chk("px_volume", out_volume, 12'd100);
    chk("px_count", event_count, 16'd1);
    step();
    chk("px_idle_valid", out_valid, 1'b0);
    chk("px_idle_price", out_price, 12'h2A0);

    // fairness from a fresh pointer
    reset_dut();
    src_data  = {12'h044, 12'h033, 12'h022, 12'h011};
    src_valid = 4'hF;
    step();
    src_valid = 4'h0;
    exp_price = '{12'h011, 12'h011, 12'h033, 12'h044};
    exp_vol   = '{12'd100, 12'h022, 12'h022, 12'h022};
    for (int i = 0; i < 4; i++) begin
      step();
      chk("rr_valid", out_valid, 1'b1);
      chk("rr_type", out_type, i[1:0]);
      chk("rr_price", out_price, exp_price[i]);
      chk("rr_volume", out_volume, exp_vol[i]);
    end
    step();
    chk("rr_idle_valid", out_valid, 1'b0);
    chk("rr_idle_price", out_price, 12'h011);
    chk("rr_idle_volume", out_volume, 12'h022);
    src_data  = {12'h0A4, 12'h0A3, 12'h0A2, 12'h0A1};
    src_valid = 4'hF;
    step();
    src_valid = 4'h0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("rr2_type", out_type, i[1:0]);
    end
    chk("rr2_count", event_count, 16'd8);

    // buy isolation
    src_valid = 4'b0001;
    src_data[11:0] = 12'h100;
    step();
    src_valid = 4'b0100;
    src_data[35:24] = 12'h155;
    step();
    src_valid = 4'b0000;
    chk("buy_px_price", out_price, 12'h100);
    step();
    chk("buy_type", out_type, 2'd2);
    chk("buy_price", out_price, 12'h155);
    step();
    chk("buy_idle_valid", out_valid, 1'b0);
    chk("buy_idle_price", out_price, 12'h100);

    // backpressure: steady drain on ch2
    reset_dut();
    src_valid = 4'b0100;
    for (int i = 0; i < 6; i++) begin
      src_data[35:24] = 12'h200 + 12'(i);
      step();
      chk("bp_ready2", src_ready[2], 1'b1);
      chk("bp_level2", lvl(2), 3'd1);
      if (i > 0) begin
        chk("bp_drain_price", out_price, 12'h200 + 12'(i - 1));
      end
    end
    src_valid = 4'b0000;
    step();
    chk("bp_last_price", out_price, 12'h205);
    chk("bp_empty", lvl(2), 3'd0);

    // stall ch2 by competing with ch0
    src_valid = 4'b0101;
    for (int i = 0; i < 5; i++) begin
      step();
    end
    chk("st_level0", lvl(0), 3'd3);
    chk("st_level2", lvl(2), 3'd3);
    step();
    chk("st_full_level2", lvl(2), 3'd4);
    chk("st_full_ready2", src_ready[2], 1'b0);
    step();
    chk("st_no_push_level2", lvl(2), 3'd3);
    chk("st_full_level0", lvl(0), 3'd4);
    chk("st_full_ready0", src_ready[0], 1'b0);
    chk("st_type", out_type, 2'd2);

    // reset mid-operation discards queued data
    src_valid = 4'b0000;
    rst = 1'b1;
    step();
    chk("mid_rst_level", fifo_level, 12'h000);
    chk("mid_rst_count", event_count, 16'd0);
    chk("mid_rst_ready", src_ready, 4'h0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("mid_rst_valid", out_valid, 1'b0);
      chk("mid_rst_level_after", fifo_level, 12'h000);
    end

    // counter saturation
    force dut.event_cnt_r = 16'hFFFD;
    #1;
    release dut.event_cnt_r;
    chk("sat_preload", event_count, 16'hFFFD);
    src_valid = 4'b0010;
    src_data[23:12] = 12'h0EE;
    step();
    step();
    chk("sat_1", event_count, 16'hFFFE);
    step();
    chk("sat_2", event_count, 16'hFFFF);
    src_valid = 4'b0000;
    step();
    chk("sat_3", event_count, 16'hFFFF);
    chk("sat_valid", out_valid, 1'b1);
    chk("sat_volume", out_volume, 12'h0EE);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
